// File: rtl/mem_stage.sv
// Pipeline MEM stage: EX/MEM register, data-bus access FSM with timeout,
// store lane formatting, load extraction and the MEM/WB register.
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] alu_result_ex,
  input  logic [31:0] real_rs2_data_ex,
  input  logic        valid_ex,
  input  logic        mem_read_ex,
  input  logic        mem_write_ex,
  input  logic        reg_write_ex,
  input  logic        wb_sel_ex,
  input  logic [2:0]  funct3_ex,
  input  logic [4:0]  rd_ex,
  input  logic        flush_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic [31:0] reg_write_data_mem,
  output logic [4:0]  rd_mem,
  output logic        reg_write_mem,
  output logic [31:0] reg_write_data_wb,
  output logic [4:0]  rd_wb,
  output logic        reg_write_wb,
  output logic        misalign_mem,
  output logic        bus_err_mem
);
  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, WAIT} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        valid_q, mem_read_q, mem_write_q, reg_write_q, wb_sel_q;
  logic [2:0]  funct3_q;
  logic [4:0]  rd_q;
  logic [31:0] addr_q, rs2_q;

  logic        wb_rw_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;

  logic        is_word, is_half, mem_op, mis, acc;
  logic        done, abandon, stall;
  logic [31:0] wdata, lane_b, lane_h, load_data;
  logic [3:0]  be;

  assign is_word = (funct3_q[1:0] == 2'b10);
  assign is_half = (funct3_q[1:0] == 2'b01);
  assign mem_op  = valid_q & (mem_read_q | mem_write_q);
  assign mis     = mem_op & ((is_word & (|addr_q[1:0])) | (is_half & addr_q[0]));
  assign acc     = mem_op & ~mis;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    abandon = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (acc) begin
          if (dmem_ack) begin
            done = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = '0;
          end
        end
      end
      WAIT: begin
        if (dmem_ack) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          abandon = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The EX/MEM entry is held while stalled, so WAIT always sees the same access.
  assign stall = acc & ~done & ~abandon;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      reg_write_q <= 1'b0;
      wb_sel_q    <= 1'b0;
      funct3_q    <= '0;
      rd_q        <= '0;
      addr_q      <= '0;
      rs2_q       <= '0;
    end else if (!stall) begin
      valid_q     <= valid_ex & ~flush_mem;
      mem_read_q  <= mem_read_ex;
      mem_write_q <= mem_write_ex;
      reg_write_q <= reg_write_ex;
      wb_sel_q    <= wb_sel_ex;
      funct3_q    <= funct3_ex;
      rd_q        <= rd_ex;
      addr_q      <= alu_result_ex;
      rs2_q       <= real_rs2_data_ex;
    end
  end

  always_comb begin
    wdata = rs2_q;
    be    = 4'b1111;
    if (is_half) begin
      wdata = {2{rs2_q[15:0]}};
      be    = 4'b0011 << {addr_q[1], 1'b0};
    end else if (!is_word) begin
      wdata = {4{rs2_q[7:0]}};
      be    = 4'b0001 << addr_q[1:0];
    end
  end

  always_comb begin
    lane_b = dmem_rdata >> {addr_q[1:0], 3'b000};
    lane_h = dmem_rdata >> {addr_q[1], 4'b0000};
    if (is_word) begin
      load_data = dmem_rdata;
    end else if (is_half) begin
      load_data = funct3_q[2] ? {16'h0000, lane_h[15:0]} : {{16{lane_h[15]}}, lane_h[15:0]};
    end else begin
      load_data = funct3_q[2] ? {24'h000000, lane_b[7:0]} : {{24{lane_b[7]}}, lane_b[7:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_rw_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else if (stall) begin
      wb_rw_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      wb_rw_q   <= valid_q & reg_write_q & ~mis & ~abandon & (rd_q != 5'd0);
      wb_rd_q   <= rd_q;
      wb_data_q <= wb_sel_q ? load_data : addr_q;
    end
  end

  // Every output is forced low while reset is asserted, even before the first edge.
  assign dmem_req           = rst_n & acc;
  assign dmem_we            = dmem_req & mem_write_q;
  assign dmem_addr          = dmem_req ? {addr_q[31:2], 2'b00} : '0;
  assign dmem_wdata         = dmem_req ? wdata : '0;
  assign dmem_be            = dmem_req ? be : '0;
  assign mem_stall          = rst_n & stall;
  assign misalign_mem       = rst_n & mis;
  assign bus_err_mem        = rst_n & abandon;
  assign reg_write_mem      = rst_n & valid_q & reg_write_q & ~mis & ~mem_read_q;
  assign rd_mem             = rst_n ? rd_q : '0;
  assign reg_write_data_mem = rst_n ? addr_q : '0;
  assign reg_write_wb       = rst_n & wb_rw_q;
  assign rd_wb              = rst_n ? wb_rd_q : '0;
  assign reg_write_data_wb  = rst_n ? wb_data_q : '0;
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed literal cases plus randomized
// traffic compared each cycle against a transaction-level reference model.
module tb_mem_stage;
  localparam int unsigned TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] alu_result_ex, real_rs2_data_ex;
  logic        valid_ex, mem_read_ex, mem_write_ex, reg_write_ex, wb_sel_ex;
  logic [2:0]  funct3_ex;
  logic [4:0]  rd_ex;
  logic        flush_mem;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        mem_stall;
  logic [31:0] reg_write_data_mem;
  logic [4:0]  rd_mem;
  logic        reg_write_mem;
  logic [31:0] reg_write_data_wb;
  logic [4:0]  rd_wb;
  logic        reg_write_wb;
  logic        misalign_mem, bus_err_mem;

  mem_stage #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_result_ex(alu_result_ex), .real_rs2_data_ex(real_rs2_data_ex),
    .valid_ex(valid_ex), .mem_read_ex(mem_read_ex), .mem_write_ex(mem_write_ex),
    .reg_write_ex(reg_write_ex), .wb_sel_ex(wb_sel_ex), .funct3_ex(funct3_ex),
    .rd_ex(rd_ex), .flush_mem(flush_mem),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .mem_stall(mem_stall),
    .reg_write_data_mem(reg_write_data_mem), .rd_mem(rd_mem), .reg_write_mem(reg_write_mem),
    .reg_write_data_wb(reg_write_data_wb), .rd_wb(rd_wb), .reg_write_wb(reg_write_wb),
    .misalign_mem(misalign_mem), .bus_err_mem(bus_err_mem)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: the access currently in MEM and how long it has waited.
  logic        m_valid = 0, m_mrd = 0, m_mwr = 0, m_rw = 0, m_wbsel = 0;
  logic [2:0]  m_f3 = '0;
  logic [4:0]  m_rd = '0;
  logic [31:0] m_alu = '0, m_data = '0;
  int unsigned m_waited = 0;
  logic        w_rw = 0;
  logic [4:0]  w_rd = '0;
  logic [31:0] w_data = '0;

  logic        s_req, s_we, s_stall, s_mis, s_berr, s_rw_mem, s_rw_wb;
  logic [31:0] s_addr, s_wd, s_wbd;
  logic [3:0]  s_be;
  logic [4:0]  s_rdwb;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int unsigned size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b10:   return 4;
      2'b01:   return 2;
      default: return 1;
    endcase
  endfunction

  function automatic logic [31:0] load_fmt(input logic [31:0] w, input logic [31:0] a,
                                           input logic [2:0] f3);
    int unsigned sz;
    logic [31:0] v;
    sz = size_of(f3);
    if (sz == 4) return w;
    v = w >> (8 * (a % 4));
    if (sz == 2) begin
      v = v & 32'h0000_FFFF;
      if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = v & 32'h0000_00FF;
      if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
    end
    return v;
  endfunction

  // One clock: called at a falling edge with inputs already applied; returns at the next one.
  task automatic cyc();
    int unsigned sz;
    logic mop, mis, req, tmo, stl;
    logic [31:0] ld, e_wd;
    logic [3:0] e_be;
    #2;
    sz   = size_of(m_f3);
    mop  = m_valid && (m_mrd || m_mwr);
    mis  = mop && ((m_alu % sz) != 0);
    req  = rst_n && mop && !mis;
    tmo  = req && !dmem_ack && (m_waited == TMO);
    stl  = req && !dmem_ack && !tmo;
    ld   = load_fmt(dmem_rdata, m_alu, m_f3);
    e_be = 4'(((32'd1 << sz) - 1) << (m_alu % 4));
    e_wd = (sz == 4) ? m_data : (sz == 2) ? {2{m_data[15:0]}} : {4{m_data[7:0]}};

    s_req = dmem_req; s_we = dmem_we; s_stall = mem_stall; s_mis = misalign_mem;
    s_berr = bus_err_mem; s_rw_mem = reg_write_mem; s_rw_wb = reg_write_wb;
    s_addr = dmem_addr; s_wd = dmem_wdata; s_be = dmem_be; s_wbd = reg_write_data_wb;
    s_rdwb = rd_wb;

    chk("dmem_req", 32'(dmem_req), 32'(req));
    chk("mem_stall", 32'(mem_stall), 32'(stl));
    chk("misalign_mem", 32'(misalign_mem), 32'(rst_n && mis));
    chk("bus_err_mem", 32'(bus_err_mem), 32'(tmo));
    chk("reg_write_mem", 32'(reg_write_mem), 32'(rst_n && m_valid && m_rw && !mis && !m_mrd));
    chk("rd_mem", 32'(rd_mem), rst_n ? 32'(m_rd) : 32'd0);
    chk("reg_write_data_mem", reg_write_data_mem, rst_n ? m_alu : 32'd0);
    chk("reg_write_wb", 32'(reg_write_wb), 32'(rst_n && w_rw));
    if (req) begin
      chk("dmem_addr", dmem_addr, m_alu & ~32'd3);
      chk("dmem_we", 32'(dmem_we), 32'(m_mwr));
      if (m_mwr) begin
        chk("dmem_be", 32'(dmem_be), 32'(e_be));
        chk("dmem_wdata", dmem_wdata, e_wd);
      end
    end
    if (!rst_n || w_rw) begin
      chk("rd_wb", 32'(rd_wb), rst_n ? 32'(w_rd) : 32'd0);
      chk("reg_write_data_wb", reg_write_data_wb, rst_n ? w_data : 32'd0);
    end

    @(posedge clk);
    if (!rst_n) begin
      m_valid = 0; m_mrd = 0; m_mwr = 0; m_rw = 0; m_wbsel = 0; m_f3 = '0;
      m_rd = '0; m_alu = '0; m_data = '0; m_waited = 0;
      w_rw = 0; w_rd = '0; w_data = '0;
    end else if (stl) begin
      w_rw = 0;
      m_waited++;
    end else begin
      w_rw     = m_valid && m_rw && !mis && !tmo && (m_rd != 0);
      w_rd     = m_rd;
      w_data   = m_wbsel ? ld : m_alu;
      m_waited = 0;
      m_valid  = valid_ex && !flush_mem;
      m_mrd = mem_read_ex; m_mwr = mem_write_ex; m_rw = reg_write_ex; m_wbsel = wb_sel_ex;
      m_f3 = funct3_ex; m_rd = rd_ex; m_alu = alu_result_ex; m_data = real_rs2_data_ex;
    end
    @(negedge clk);
  endtask

  task automatic set_op(input logic rdop, input logic wrop, input logic rw, input logic [2:0] f3,
                        input logic [4:0] rd, input logic [31:0] addr, input logic [31:0] data);
    valid_ex = 1; mem_read_ex = rdop; mem_write_ex = wrop; reg_write_ex = rw;
    wb_sel_ex = rdop; funct3_ex = f3; rd_ex = rd; alu_result_ex = addr;
    real_rs2_data_ex = data; flush_mem = 0;
  endtask

  task automatic set_idle();
    valid_ex = 0; mem_read_ex = 0; mem_write_ex = 0; reg_write_ex = 0; wb_sel_ex = 0;
    flush_mem = 0;
  endtask

  task automatic lb_test(input logic [2:0] f3, input logic [31:0] exp);
    int stalls, bubbles;
    stalls = 0; bubbles = 0;
    set_op(1, 0, 1, f3, 5'd9, 32'h103, 32'h0);
    dmem_ack = 0; cyc();
    set_idle();
    for (int k = 0; k < 4; k++) begin
      dmem_ack = (k == 3); dmem_rdata = 32'h80FF_0000;
      cyc();
      stalls += int'(s_stall);
      if (k >= 1 && !s_rw_wb) bubbles++;
    end
    dmem_ack = 0; cyc();
    chk("lb_stall_cycles", 32'(stalls), 32'd3);
    chk("lb_wb_bubbles", 32'(bubbles), 32'd3);
    chk("lb_wb_data", s_wbd, exp);
    chk("lb_wb_rw", 32'(s_rw_wb), 32'd1);
  endtask

  initial begin
    int stalls, ackpct, r;
    logic seen;
    logic [2:0] f3l [5];
    f3l[0] = 3'b000; f3l[1] = 3'b001; f3l[2] = 3'b010; f3l[3] = 3'b100; f3l[4] = 3'b101;
    rst_n = 0; set_idle(); funct3_ex = 0; rd_ex = 0; alu_result_ex = 0; real_rs2_data_ex = 0;
    dmem_ack = 0; dmem_rdata = 0;
    @(negedge clk);
    cyc(); cyc();
    chk("reset_req", 32'(s_req), 32'd0);
    chk("reset_stall", 32'(s_stall), 32'd0);
    chk("reset_rw_wb", 32'(s_rw_wb), 32'd0);
    rst_n = 1;

    set_op(1, 0, 1, 3'b010, 5'd3, 32'h100, 32'h0);
    cyc();
    set_idle(); dmem_ack = 1; dmem_rdata = 32'hDEAD_BEEF;
    cyc();
    chk("lw0_req", 32'(s_req), 32'd1);
    chk("lw0_stall", 32'(s_stall), 32'd0);
    dmem_ack = 0; cyc();
    chk("lw0_wb_data", s_wbd, 32'hDEAD_BEEF);
    chk("lw0_wb_rw", 32'(s_rw_wb), 32'd1);

    lb_test(3'b000, 32'hFFFF_FF80);
    lb_test(3'b100, 32'h0000_0080);

    set_op(0, 1, 0, 3'b001, 5'd5, 32'h202, 32'h1234_ABCD);
    cyc();
    set_idle(); dmem_ack = 1;
    cyc();
    chk("sh_we", 32'(s_we), 32'd1);
    chk("sh_addr", s_addr, 32'h200);
    chk("sh_be", 32'(s_be), 32'b1100);
    chk("sh_wdata", s_wd, 32'hABCD_ABCD);
    dmem_ack = 0; cyc();
    chk("sh_wb_rw", 32'(s_rw_wb), 32'd0);

    set_op(1, 0, 1, 3'b010, 5'd7, 32'h101, 32'h0);
    cyc();
    set_idle(); dmem_ack = 1;
    cyc();
    chk("mis_flag", 32'(s_mis), 32'd1);
    chk("mis_req", 32'(s_req), 32'd0);
    chk("mis_stall", 32'(s_stall), 32'd0);
    dmem_ack = 0; cyc();
    chk("mis_pulse_end", 32'(s_mis), 32'd0);
    chk("mis_wb_rw", 32'(s_rw_wb), 32'd0);

    set_op(1, 0, 1, 3'b010, 5'd8, 32'h400, 32'h0);
    cyc();
    set_idle(); dmem_ack = 0;
    stalls = 0; seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      cyc();
      stalls += int'(s_stall);
      seen = s_berr;
    end
    chk("tmo_seen", 32'(seen), 32'd1);
    chk("tmo_stall_cycles", 32'(stalls), 32'(TMO));
    cyc();
    chk("tmo_wb_rw", 32'(s_rw_wb), 32'd0);
    chk("tmo_pulse_end", 32'(s_berr), 32'd0);
    chk("tmo_stall_end", 32'(s_stall), 32'd0);

    set_op(1, 0, 1, 3'b010, 5'd4, 32'h300, 32'h0);
    cyc();
    set_idle();
    for (int k = 0; k < 3; k++) cyc();
    rst_n = 0; cyc();
    chk("rstw_req", 32'(s_req), 32'd0);
    chk("rstw_berr", 32'(s_berr), 32'd0);
    rst_n = 1; cyc();
    chk("rstw_req_after", 32'(s_req), 32'd0);
    chk("rstw_stall_after", 32'(s_stall), 32'd0);
    chk("rstw_wb_rw", 32'(s_rw_wb), 32'd0);
    chk("rstw_wb_data", s_wbd, 32'd0);
    chk("rstw_wb_rd", 32'(s_rdwb), 32'd0);
    chk("rstw_berr_after", 32'(s_berr), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      ackpct = (i < 1000) ? 50 : (i < 2000) ? 20 : (((i / 60) % 2) == 0) ? 0 : 60;
      rst_n = ($urandom_range(0, 199) != 0);
      valid_ex = ($urandom_range(0, 3) != 0);
      r = int'($urandom_range(0, 9));
      mem_read_ex = (r < 4);
      mem_write_ex = (r >= 4 && r < 7);
      if (mem_read_ex) funct3_ex = f3l[$urandom_range(0, 4)];
      else if (mem_write_ex) funct3_ex = f3l[$urandom_range(0, 2)];
      else funct3_ex = 3'($urandom_range(0, 7));
      reg_write_ex = mem_read_ex ? 1'b1 : mem_write_ex ? ($urandom_range(0, 7) == 0)
                                                       : 1'($urandom_range(0, 1));
      wb_sel_ex = mem_read_ex;
      rd_ex = 5'($urandom_range(0, 31));
      alu_result_ex = $urandom();
      real_rs2_data_ex = $urandom();
      flush_mem = ($urandom_range(0, 7) == 0);
      dmem_ack = (int'($urandom_range(0, 99)) < ackpct);
      dmem_rdata = $urandom();
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
